pipelined_addsub: RTL

- Parametrised, pipelined two's-complement adder/subtractor. Successor to the team's fixed 4-bit ripple-carry adder.
- Splits the WIDTH-bit carry chain into STAGES equal chunks, with one register stage per chunk.
- Adds a subtract mode, carry/borrow-in, a signed-overflow flag and a valid/ready handshake with backpressure.
- Used as the arithmetic primitive in datapaths needing wide operands at high clock rate.

---
 rtl/addsub_pkg.sv | 14 +
 rtl/addsub_chunk.sv | 29 ++
 rtl/pipelined_addsub.sv | 131 +++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and elaboration-time helpers for the pipelined adder/subtractor.
package addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } addsub_op_e;

  // Legal geometry: at least 2 bits, 1..WIDTH stages, equal-sized chunks.
  function automatic bit addsub_params_ok(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) && ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/addsub_chunk.sv
// Combinational C-bit ripple full-adder chain; one carry-chain slice of the pipeline.
module addsub_chunk #(
  parameter int C = 4
) (
  input  logic [C-1:0] a,
  input  logic [C-1:0] b,
  input  logic         cin,
  output logic [C-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [C:0] carry;

  // Bitwise ripple: carry[i] is the carry into bit i.
  always_comb begin
    carry    = '0;
    sum      = '0;
    carry[0] = cin;
    for (int i = 0; i < C; i++) begin
      sum[i]       = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign cout  = carry[C];
  assign c_msb = carry[C - 1];

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined two's-complement adder/subtractor: one register stage per C-bit carry chunk,
// valid/ready handshake with a combinational backward ready chain.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int C = WIDTH / STAGES;

  if (!addsub_params_ok(WIDTH, STAGES)) begin : g_param_check
    $error("pipelined_addsub: WIDTH must be >= 2 and divisible by STAGES (1..WIDTH)");
  end

  logic [STAGES-1:0] valid;
  logic [STAGES-1:0] load;
  logic              downstream;

  // A stage loads when it is empty or when its successor loads; out_ready closes the chain.
  always_comb begin
    load       = '0;
    downstream = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      load[k]    = ~valid[k] | downstream;
      downstream = load[k];
    end
  end

  assign in_ready = load[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             stage_valid;
    logic [WIDTH-1:0] stage_res;
    logic [WIDTH-1:0] stage_a;
    logic [WIDTH-1:0] stage_b;
    logic             stage_carry;

    logic             src_valid;
    logic             src_carry;
    logic [WIDTH-1:0] src_res;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic [WIDTH-1:0] next_res;
    logic [C-1:0]     chunk_sum;
    logic             chunk_cout;
    logic             chunk_c_msb;

    // Stage 0 folds SUB into an add: B and the borrow-in are inverted once at entry.
    if (k == 0) begin : g_src
      assign src_valid = in_valid;
      assign src_a     = a;
      assign src_b     = (addsub_op_e'(op) == OP_SUB) ? ~b : b;
      assign src_carry = (addsub_op_e'(op) == OP_SUB) ? ~cin : cin;
      assign src_res   = '0;
    end else begin : g_src
      assign src_valid = g_stage[k-1].stage_valid;
      assign src_a     = g_stage[k-1].stage_a;
      assign src_b     = g_stage[k-1].stage_b;
      assign src_carry = g_stage[k-1].stage_carry;
      assign src_res   = g_stage[k-1].stage_res;
    end

    addsub_chunk #(.C(C)) u_chunk (
      .a     (src_a[k*C +: C]),
      .b     (src_b[k*C +: C]),
      .cin   (src_carry),
      .sum   (chunk_sum),
      .cout  (chunk_cout),
      .c_msb (chunk_c_msb)
    );

    // Insert this chunk's sum into the partial result carried from upstream.
    always_comb begin
      next_res              = src_res;
      next_res[k*C +: C]    = chunk_sum;
    end

    // Stage register; holds contents while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        stage_valid <= 1'b0;
        stage_res   <= '0;
        stage_a     <= '0;
        stage_b     <= '0;
        stage_carry <= 1'b0;
      end else if (load[k]) begin
        stage_valid <= src_valid;
        stage_res   <= next_res;
        stage_a     <= src_a;
        stage_b     <= src_b;
        stage_carry <= chunk_cout;
      end
    end

    assign valid[k] = stage_valid;

    if (k == STAGES - 1) begin : g_last
      logic ovf_flag;

      // Signed overflow: carry into MSB differs from carry out of MSB.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_flag <= 1'b0;
        end else if (load[k]) begin
          ovf_flag <= chunk_c_msb ^ chunk_cout;
        end
      end

      assign out_valid = stage_valid;
      assign sum       = stage_res;
      assign cout      = stage_carry;
      assign ovf       = ovf_flag;
    end
  end

endmodule
